// File: rtl/sram_bus_sequencer.sv
// rtl/sram_bus_sequencer.sv - arbitrated setup/strobe/hold sequencer for the external SRAM bus
module sram_bus_sequencer #(
  parameter int NCH   = 2,
  parameter int AW    = 21,
  parameter int DW    = 8,
  parameter int RD_WS = 2,
  parameter int WR_WS = 2,
  parameter int RR    = 0
) (
  input  logic              clk6x,
  input  logic              resetn,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [AW-1:0]     MA,
  input  logic [DW-1:0]     MD_i,
  output logic [DW-1:0]     MD_o,
  output logic              MD_oe,
  output logic              M1CSn,
  output logic              MRDn,
  output logic              MWRn
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic            we_l_q, we_l_d;

  logic [AW-1:0]   ma_q, ma_d;
  logic [DW-1:0]   md_o_q, md_o_d;
  logic            md_oe_q, md_oe_d;
  logic            cs_n_q, cs_n_d;
  logic            rd_n_q, rd_n_d;
  logic            wr_n_q, wr_n_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;

  logic            any_req;
  logic            arb_found;
  logic [GW-1:0]   win;
  int              arb_start;
  int              arb_idx;
  logic [CW-1:0]   ws_last;

  // Arbitration: scan upward from the start index (0 for fixed priority,
  // one past the last grant for round-robin) and take the first requester.
  always_comb begin
    any_req   = |req;
    arb_found = 1'b0;
    win       = '0;
    arb_idx   = 0;
    arb_start = (RR != 0) ? (int'(last_grant_q) + 1) : 0;
    for (int k = 0; k < NCH; k++) begin
      arb_idx = (arb_start + k) % NCH;
      if (!arb_found && req[GW'(arb_idx)]) begin
        win       = GW'(arb_idx);
        arb_found = 1'b1;
      end
    end
  end

  // Strobe length depends on the direction of the access in flight.
  always_comb begin
    ws_last = we_l_q ? CW'(WR_WS - 1) : CW'(RD_WS - 1);
  end

  // Next-state and next-output logic; every output is the registered value
  // of what the bus should show during the following cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_l_d       = we_l_q;
    ma_d         = ma_q;
    md_o_d       = md_o_q;
    md_oe_d      = md_oe_q;
    cs_n_d       = cs_n_q;
    rd_n_d       = rd_n_q;
    wr_n_d       = wr_n_q;
    ack_d        = '0;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        cs_n_d  = 1'b1;
        md_oe_d = 1'b0;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        if (any_req) begin
          state_d = SETUP;
          grant_d = win;
          we_l_d  = we[win];
          ma_d    = addr[int'(win)*AW +: AW];
          cs_n_d  = 1'b0;
          if (we[win]) begin
            md_o_d  = wdata[int'(win)*DW +: DW];
            md_oe_d = 1'b1;
          end
        end
      end

      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
        rd_n_d  = we_l_q;
        wr_n_d  = !we_l_q;
      end

      STROBE: begin
        if (cnt_q == ws_last) begin
          state_d        = HOLD;
          rd_n_d         = 1'b1;
          wr_n_d         = 1'b1;
          ack_d[grant_q] = 1'b1;
          if (!we_l_q) begin
            rdata_d = MD_i;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        md_oe_d = 1'b0;
        if (RR != 0) begin
          last_grant_d = grant_q;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        md_oe_d = 1'b0;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any access in flight.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(NCH - 1);
      we_l_q       <= 1'b0;
      ma_q         <= '0;
      md_o_q       <= '0;
      md_oe_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_l_q       <= we_l_d;
      ma_q         <= ma_d;
      md_o_q       <= md_o_d;
      md_oe_q      <= md_oe_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign MA    = ma_q;
  assign MD_o  = md_o_q;
  assign MD_oe = md_oe_q;
  assign M1CSn = cs_n_q;
  assign MRDn  = rd_n_q;
  assign MWRn  = wr_n_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule
